// File: rtl/hsi_msg_scheduler.sv
// hsi_msg_scheduler
//   Shares one HSI coder among N_SRC message sources. Requests are latched,
//   one source at a time is granted by fixed priority (index 0 highest), the
//   coder is then handed to the CRC sender, and an inter-message gap is
//   enforced before the next grant. A watchdog aborts a stuck SEND or CRC phase.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req           per-source request pulses
//   msg_end       per-source end-of-message pulses
//   crc_end       CRC sender finished pulse
//   cd_busy       coder busy
//   grant         one-hot enable of the granted source controller
//   crc_en        CRC sender enable
//   sel           one-hot connector mux select {crc_en, grant}
//   crc_clr       1-cycle pulse clearing the CRC calculator on each grant
//   busy          scheduler not idle
//   pending       latched, not yet served requests
//   overrun       1-cycle pulse: request while the same source already pending
//   timeout_err   1-cycle pulse on watchdog abort
module hsi_msg_scheduler #(
    parameter int N_SRC   = 5,
    parameter int GAP_CYC = 8,
    parameter int TIMEOUT = 4096,
    parameter int TMO_W   = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] msg_end,
    input  logic             crc_end,
    input  logic             cd_busy,
    output logic [N_SRC-1:0] grant,
    output logic             crc_en,
    output logic [N_SRC:0]   sel,
    output logic             crc_clr,
    output logic             busy,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun,
    output logic             timeout_err
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, CRC, GAP} state_t;

    state_t           state, state_d;
    logic [TMO_W-1:0] wdog, wdog_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;

    logic [N_SRC-1:0] arb, win;
    logic             msg_done, wdog_last, gap_done;

    logic [N_SRC-1:0] grant_d, pending_d, overrun_d;
    logic             crc_en_d, crc_clr_d, timeout_d;

    // A request in the current cycle is eligible alongside latched ones.
    assign arb = pending | req;

    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (arb[i] && !found) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // Only the granted source's end-of-message counts.
    assign msg_done  = |(msg_end & grant);
    assign wdog_last = (wdog == TMO_W'(TIMEOUT - 1));
    // GAP_CYC=0 behaves like 1: leave on the first coder-idle cycle.
    assign gap_done  = !cd_busy && ((32'(gap_cnt) + 32'd1) >= 32'(GAP_CYC));

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wdog        <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            crc_en      <= 1'b0;
            crc_clr     <= 1'b0;
            busy        <= 1'b0;
            pending     <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            wdog        <= wdog_d;
            gap_cnt     <= gap_cnt_d;
            grant       <= grant_d;
            crc_en      <= crc_en_d;
            crc_clr     <= crc_clr_d;
            busy        <= (state_d != IDLE);
            pending     <= pending_d;
            overrun     <= overrun_d;
            timeout_err <= timeout_d;
        end
    end

    assign sel = {crc_en, grant};

    // Next-state and counters
    always_comb begin
        state_d   = state;
        wdog_d    = wdog;
        gap_cnt_d = '0;
        case (state)
            IDLE: begin
                if (|arb) begin
                    state_d = SEND;
                    wdog_d  = '0;
                end
            end
            SEND: begin
                if (msg_done) begin
                    state_d = CRC;
                    wdog_d  = '0;
                end else if (wdog_last) begin
                    state_d = GAP;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog + 1'b1;
                end
            end
            CRC: begin
                if (crc_end || wdog_last) begin
                    state_d = GAP;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog + 1'b1;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                end else if (!cd_busy) begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        grant_d   = grant;
        crc_en_d  = crc_en;
        crc_clr_d = 1'b0;
        timeout_d = 1'b0;
        overrun_d = req & pending;
        pending_d = arb;
        case (state)
            IDLE: begin
                if (|arb) begin
                    grant_d   = win;
                    pending_d = arb & ~win;
                    crc_clr_d = 1'b1;
                end
            end
            SEND: begin
                if (msg_done) begin
                    grant_d  = '0;
                    crc_en_d = 1'b1;
                end else if (wdog_last) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            CRC: begin
                if (crc_end) begin
                    crc_en_d = 1'b0;
                end else if (wdog_last) begin
                    crc_en_d  = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hsi_msg_scheduler.sv
// tb_hsi_msg_scheduler
//   Bench for hsi_msg_scheduler. Two instances share the inputs: the main one
//   with GAP_CYC=8 and a second with GAP_CYC=0; both use TIMEOUT=20.
module tb_hsi_msg_scheduler;

    localparam int GAP = 8;
    localparam int TMO = 20;

    typedef struct packed {
        logic [4:0] grant;
        logic       crc_en;
        logic [5:0] sel;
        logic       crc_clr;
        logic       busy;
        logic [4:0] pending;
        logic [4:0] overrun;
        logic       timeout_err;
    } out_t;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] msg_end;
        logic       crc_end;
        logic       cd_busy;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] msg_end = '0;
    logic       crc_end = 1'b0;
    logic       cd_busy = 1'b0;

    logic [4:0] grant_a, pending_a, overrun_a, grant_b, pending_b, overrun_b;
    logic [5:0] sel_a, sel_b;
    logic       crc_en_a, crc_clr_a, busy_a, tmo_a;
    logic       crc_en_b, crc_clr_b, busy_b, tmo_b;

    out_t mon_a, mon_b;
    out_t exp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hsi_msg_scheduler #(.N_SRC(5), .GAP_CYC(GAP), .TIMEOUT(TMO), .TMO_W(5)) dut (
        .clk(clk), .rst(rst), .req(req), .msg_end(msg_end), .crc_end(crc_end),
        .cd_busy(cd_busy), .grant(grant_a), .crc_en(crc_en_a), .sel(sel_a),
        .crc_clr(crc_clr_a), .busy(busy_a), .pending(pending_a),
        .overrun(overrun_a), .timeout_err(tmo_a)
    );

    hsi_msg_scheduler #(.N_SRC(5), .GAP_CYC(0), .TIMEOUT(TMO), .TMO_W(5)) dut0 (
        .clk(clk), .rst(rst), .req(req), .msg_end(msg_end), .crc_end(crc_end),
        .cd_busy(cd_busy), .grant(grant_b), .crc_en(crc_en_b), .sel(sel_b),
        .crc_clr(crc_clr_b), .busy(busy_b), .pending(pending_b),
        .overrun(overrun_b), .timeout_err(tmo_b)
    );

    assign mon_a = {grant_a, crc_en_a, sel_a, crc_clr_a, busy_a, pending_a, overrun_a, tmo_a};
    assign mon_b = {grant_b, crc_en_b, sel_b, crc_clr_b, busy_b, pending_b, overrun_b, tmo_b};

    function automatic out_t mk(input logic [4:0] g, input logic ce, input logic clr,
                                input logic b, input logic [4:0] p, input logic [4:0] ov,
                                input logic to);
        out_t o;
        o.grant       = g;
        o.crc_en      = ce;
        o.sel         = {ce, g};
        o.crc_clr     = clr;
        o.busy        = b;
        o.pending     = p;
        o.overrun     = ov;
        o.timeout_err = to;
        return o;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] me,
                        input logic ce, input logic cb, input out_t e,
                        input string nm, input bit use_b = 1'b0);
        out_t want, got;
        @(negedge clk);
        rst = r; req = rq; msg_end = me; crc_end = ce; cd_busy = cb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = use_b ? mon_b : mon_a;
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b (grant,crc_en,sel,crc_clr,busy,pending,overrun,timeout_err) at %0t",
                     nm, got, want, $time);
        end
    endtask

    // GAP phase with the coder idle: GAP-1 busy cycles, then back to IDLE.
    task automatic finish_gap(input logic [4:0] p, input string nm);
        for (int i = 0; i < GAP - 1; i++)
            step(0, '0, '0, 0, 0, mk('0, 0, 0, 1, p, '0, 0), nm);
        step(0, '0, '0, 0, 0, mk('0, 0, 0, 0, p, '0, 0), {nm, "_idle"});
    endtask

    task automatic add(input logic [4:0] rq, input logic [4:0] me, input logic ce,
                       input logic cb, input out_t e);
        vec_t v;
        v.rst = 1'b0; v.req = rq; v.msg_end = me; v.crc_end = ce; v.cd_busy = cb; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // T2 as a vector table: req t0, msg_end t5, crc_end t9, coder idle from t9
        add(5'b00001, '0, 0, 0, mk(5'b00001, 0, 1, 1, '0, '0, 0));
        for (int i = 1; i <= 4; i++) add('0, '0, 0, 1, mk(5'b00001, 0, 0, 1, '0, '0, 0));
        add('0, 5'b00001, 0, 1, mk('0, 1, 0, 1, '0, '0, 0));
        for (int i = 6; i <= 8; i++) add('0, '0, 0, 1, mk('0, 1, 0, 1, '0, '0, 0));
        add('0, '0, 1, 0, mk('0, 0, 0, 1, '0, '0, 0));
        for (int i = 0; i < GAP - 1; i++) add('0, '0, 0, 0, mk('0, 0, 0, 1, '0, '0, 0));
        add('0, '0, 0, 0, mk('0, 0, 0, 0, '0, '0, 0));

        step(1, '0, '0, 0, 0, mk('0, 0, 0, 0, '0, '0, 0), "reset");
        step(1, 5'b11111, '0, 0, 0, mk('0, 0, 0, 0, '0, '0, 0), "reset_req");
        step(0, '0, '0, 0, 0, mk('0, 0, 0, 0, '0, '0, 0), "idle");

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].rst, tbl[i].req, tbl[i].msg_end, tbl[i].crc_end, tbl[i].cd_busy,
                 tbl[i].exp, $sformatf("t2_row%0d", i));

        // T3: two simultaneous requests, lower index first, other stays pending
        step(0, 5'b10100, '0, 0, 0, mk(5'b00100, 0, 1, 1, 5'b10000, '0, 0), "t3_grant2");
        step(0, '0, '0, 0, 0, mk(5'b00100, 0, 0, 1, 5'b10000, '0, 0), "t3_send");
        step(0, '0, 5'b00100, 0, 0, mk('0, 1, 0, 1, 5'b10000, '0, 0), "t3_crc");
        step(0, '0, '0, 1, 0, mk('0, 0, 0, 1, 5'b10000, '0, 0), "t3_gap");
        finish_gap(5'b10000, "t3_gap_a");
        step(0, '0, '0, 0, 0, mk(5'b10000, 0, 1, 1, '0, '0, 0), "t3_grant4");
        step(0, '0, 5'b10000, 0, 0, mk('0, 1, 0, 1, '0, '0, 0), "t3_crc4");
        step(0, '0, '0, 1, 0, mk('0, 0, 0, 1, '0, '0, 0), "t3_gap4");
        finish_gap('0, "t3_gap_b");

        // T4: overrun on repeated request; foreign msg_end ignored
        step(0, 5'b00100, '0, 0, 0, mk(5'b00100, 0, 1, 1, '0, '0, 0), "t4_grant2");
        step(0, 5'b00001, '0, 0, 0, mk(5'b00100, 0, 0, 1, 5'b00001, '0, 0), "t4_req0");
        step(0, 5'b00001, '0, 0, 0, mk(5'b00100, 0, 0, 1, 5'b00001, 5'b00001, 0), "t4_overrun");
        step(0, '0, 5'b01000, 0, 0, mk(5'b00100, 0, 0, 1, 5'b00001, '0, 0), "t4_foreign_end");
        step(0, '0, 5'b00100, 0, 0, mk('0, 1, 0, 1, 5'b00001, '0, 0), "t4_crc");
        step(0, '0, '0, 1, 0, mk('0, 0, 0, 1, 5'b00001, '0, 0), "t4_gap");
        finish_gap(5'b00001, "t4_gap_a");
        step(0, '0, '0, 0, 0, mk(5'b00001, 0, 1, 1, '0, '0, 0), "t4_grant0");
        step(0, '0, 5'b00001, 0, 0, mk('0, 1, 0, 1, '0, '0, 0), "t4_crc0");
        step(0, '0, '0, 1, 0, mk('0, 0, 0, 1, '0, '0, 0), "t4_gap0");
        finish_gap('0, "t4_gap_b");

        // T1: reset in the middle of SEND of source 2
        step(0, 5'b00100, '0, 0, 1, mk(5'b00100, 0, 1, 1, '0, '0, 0), "t1_grant2");
        step(0, '0, '0, 0, 1, mk(5'b00100, 0, 0, 1, '0, '0, 0), "t1_send");
        step(1, 5'b00011, '0, 0, 1, mk('0, 0, 0, 0, '0, '0, 0), "t1_reset");
        step(0, '0, '0, 0, 0, mk('0, 0, 0, 0, '0, '0, 0), "t1_after");

        // T5a: SEND watchdog expiry
        step(0, 5'b00010, '0, 0, 0, mk(5'b00010, 0, 1, 1, '0, '0, 0), "t5_grant1");
        for (int i = 1; i < TMO; i++)
            step(0, '0, '0, 0, 0, mk(5'b00010, 0, 0, 1, '0, '0, 0), "t5_send");
        step(0, '0, '0, 0, 0, mk('0, 0, 0, 1, '0, '0, 1), "t5_timeout");
        finish_gap('0, "t5_gap");

        // T5b: msg_end on the last allowed cycle wins, then CRC watchdog expiry
        step(0, 5'b00010, '0, 0, 0, mk(5'b00010, 0, 1, 1, '0, '0, 0), "t5b_grant1");
        for (int i = 1; i < TMO; i++)
            step(0, '0, '0, 0, 0, mk(5'b00010, 0, 0, 1, '0, '0, 0), "t5b_send");
        step(0, '0, 5'b00010, 0, 0, mk('0, 1, 0, 1, '0, '0, 0), "t5b_last_end");
        for (int i = 1; i < TMO; i++)
            step(0, '0, '0, 0, 0, mk('0, 1, 0, 1, '0, '0, 0), "t5b_crc");
        step(0, '0, '0, 0, 0, mk('0, 0, 0, 1, '0, '0, 1), "t5b_crc_timeout");
        finish_gap('0, "t5b_gap");

        // T6 on the GAP_CYC=0 instance
        step(1, '0, '0, 0, 0, mk('0, 0, 0, 0, '0, '0, 0), "t6_reset_a");
        step(1, '0, '0, 0, 0, mk('0, 0, 0, 0, '0, '0, 0), "t6_reset_b", 1'b1);
        step(0, 5'b00001, '0, 0, 0, mk(5'b00001, 0, 1, 1, '0, '0, 0), "t6_grant0", 1'b1);
        step(0, '0, 5'b00001, 0, 1, mk('0, 1, 0, 1, '0, '0, 0), "t6_crc", 1'b1);
        step(0, '0, '0, 1, 1, mk('0, 0, 0, 1, '0, '0, 0), "t6_gap", 1'b1);
        for (int i = 0; i < 20; i++)
            step(0, (i == 5) ? 5'b01000 : 5'b00000, '0, 0, 1,
                 mk('0, 0, 0, 1, (i >= 5) ? 5'b01000 : 5'b00000, '0, 0), "t6_hold", 1'b1);
        step(0, '0, '0, 0, 0, mk('0, 0, 0, 0, 5'b01000, '0, 0), "t6_idle", 1'b1);
        step(0, '0, '0, 0, 0, mk(5'b01000, 0, 1, 1, '0, '0, 0), "t6_grant3", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
